// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Purpose:
//   Multi-entry register file for the MIPS datapath. Holds Depth entries of
//   Width bits, written through one synchronous byte-enabled port and read
//   through two combinational ports. Entry 0 can be hardwired to zero, and a
//   read of the entry being written this cycle can return the merged write
//   data (bypass) so decode sees writeback results without a stall.
//
// Parameters:
//   Width     - data width in bits, multiple of 8
//   Depth     - number of entries (need not be a power of two)
//   AddrWidth - address width, 2**AddrWidth >= Depth
//   ZeroReg   - 1: entry 0 always reads 0 and ignores writes
//   Bypass    - 1: reading the address being written returns merged data
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low; clears every entry while low
//   we           write enable
//   wa           write address
//   wd           write data
//   wbe          byte enables, bit i covers wd[8i+7:8i]
//   ra1 / rd1    read address / data, port 1
//   ra2 / rd2    read address / data, port 2
// ---------------------------------------------------------------------------
module register_file #(
  parameter int Width     = 32,
  parameter int Depth     = 32,
  parameter int AddrWidth = 5,
  parameter int ZeroReg   = 1,
  parameter int Bypass    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AddrWidth-1:0]   wa,
  input  logic [Width-1:0]       wd,
  input  logic [Width/8-1:0]     wbe,
  input  logic [AddrWidth-1:0]   ra1,
  output logic [Width-1:0]       rd1,
  input  logic [AddrWidth-1:0]   ra2,
  output logic [Width-1:0]       rd2
);

  localparam int NumBytes = Width / 8;

  // One extra bit so that Depth == 2**AddrWidth is still representable.
  localparam logic [AddrWidth:0] DepthLimit = (AddrWidth + 1)'(Depth);

  logic [Width-1:0]     mem_q [Depth];
  logic [Width-1:0]     mem_d [Depth];

  logic                 wa_in_range;
  logic                 write_hit;
  logic [Width-1:0]     wa_stored;
  logic [Width-1:0]     merged;

  logic [AddrWidth-1:0] ra_arr [2];
  logic [Width-1:0]     rd_arr [2];

  // Decide whether this cycle's write lands anywhere, and build the
  // byte-wise merge of the write data over the currently stored word. The
  // same merged word feeds both the storage update and the bypass path, so
  // a bypassed read always equals what the entry holds after the edge.
  always_comb begin
    wa_in_range = ({1'b0, wa} < DepthLimit);
    write_hit   = we && wa_in_range && !((ZeroReg != 0) && (wa == '0));
    wa_stored   = wa_in_range ? mem_q[wa] : '0;
    merged      = wa_stored;
    for (int b = 0; b < NumBytes; b++) begin
      if (wbe[b]) begin
        merged[8*b +: 8] = wd[8*b +: 8];
      end
    end
  end

  // Next-state of the array: only the addressed entry changes, and only
  // when the write is not ignored (out of range or hardwired zero).
  always_comb begin
    mem_d = mem_q;
    if (write_hit) begin
      mem_d[wa] = merged;
    end
  end

  // Asynchronous reset dominates any coincident clock edge, so a write
  // pending while reset is low is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_arr[0] = ra1;
  assign ra_arr[1] = ra2;
  assign rd1       = rd_arr[0];
  assign rd2       = rd_arr[1];

  // Both read ports share identical logic. Out-of-range addresses and the
  // hardwired zero entry read as 0; bypass is gated by reset so the outputs
  // stay 0 while reset is held.
  for (genvar p = 0; p < 2; p++) begin : g_read
    always_comb begin
      rd_arr[p] = '0;
      if (({1'b0, ra_arr[p]} < DepthLimit) &&
          !((ZeroReg != 0) && (ra_arr[p] == '0))) begin
        if ((Bypass != 0) && reset && write_hit && (ra_arr[p] == wa)) begin
          rd_arr[p] = merged;
        end else begin
          rd_arr[p] = mem_q[ra_arr[p]];
        end
      end
    end
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised multi-entry register file for the MIPS datapath; generalises the single load-enabled register into an array of Depth registers.
- One synchronous write port with byte enables and two combinational read ports.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Sits between instruction decode (read addresses) and writeback (write port).

Parameters:
- Width, 32, data width in bits; must be a multiple of 8.
- Depth, 32, number of registers; need not be a power of two.
- AddrWidth, 5, address width; must satisfy 2^AddrWidth >= Depth.
- ZeroReg, 1, 1 = entry 0 always reads 0 and ignores writes.
- Bypass, 1, 1 = a read of the address being written this cycle returns the merged write data.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; all entries cleared while reset = 0.
- we  input  1  write enable.
- wa  input  AddrWidth  write address.
- wd  input  Width  write data.
- wbe  input  Width/8  byte enables; bit i covers wd[8i+7:8i].
- ra1  input  AddrWidth  read address, port 1.
- rd1  output  Width  read data, port 1.
- ra2  input  AddrWidth  read address, port 2.
- rd2  output  Width  read data, port 2.

Behaviour:
- Storage: Depth entries of Width bits.
- Reset:
  - Falling edge of reset, or reset held at 0, forces every entry to 0 immediately, independent of clock.
  - While reset = 0, rd1 = rd2 = 0 and writes are ignored.
  - Release is synchronous-safe: the first write is accepted on the first rising clock edge with reset = 1.
- Write:
  - On the rising clock edge with reset = 1, we = 1, wa < Depth, and not (ZeroReg = 1 and wa = 0): each byte i with wbe[i] = 1 takes wd byte i.
  - Bytes with wbe[i] = 0 keep their old value.
  - we = 1 with wbe = 0 changes nothing.
- Ignored writes:
  - wa >= Depth: no entry changes; no aliasing onto a lower entry.
  - ZeroReg = 1 and wa = 0: entry 0 stays 0.
- Read:
  - Purely combinational, zero latency: rdN = entry[raN].
  - raN >= Depth: rdN = 0.
  - ZeroReg = 1 and raN = 0: rdN = 0 regardless of any write.
- Bypass = 1:
  - Applies when we = 1, reset = 1, raN = wa, and the write is not ignored.
  - rdN = byte-wise merge: wd byte where wbe[i] = 1, stored byte otherwise.
  - The bypassed value equals what the entry will hold after the edge.
- Bypass = 0: rdN shows the old value until the edge, then the new value.
- Both ports may address the same entry; both return identical data, with bypass applied equally to each.
- Timing:
  - A write becomes visible through storage on the cycle after the edge.
  - With Bypass = 1 it is visible in the same cycle.
  - Back-to-back writes to the same address: the last write wins, byte-wise.
- Reset asserted mid-cycle with we = 1: reset wins. The entry is 0 and the pending write is dropped even if a clock edge coincides.
- No internal state other than the storage array; no X on outputs after reset for any address input.

Test Plan:
- Reset then scan: reset = 0 for 2 cycles, release, read all 32 addresses on both ports -> every rd = 0x00000000.
- Full write and read-back: write 0xDEADBEEF to r5 with wbe = 4'b1111, next cycle ra1 = 5, ra2 = 5 -> rd1 = rd2 = 0xDEADBEEF.
- Byte enables: r5 = 0xDEADBEEF, write 0x11223344 with wbe = 4'b0101 -> r5 = 0xDE22BE44.
- Zero register: write 0xFFFFFFFF to r0 -> rd1 = 0 with ra1 = 0, in the same cycle and after the edge.
- Bypass and bypass-off:
  - Bypass = 1: r7 = 0xAAAAAAAA; in the write cycle (we = 1, wa = 7, wd = 0x12345678, wbe = 4'b0011) with ra2 = 7 -> rd2 = 0xAAAA5678 before the edge, and the same value after it.
  - Bypass = 0, same stimulus -> rd2 = 0xAAAAAAAA before the edge, 0xAAAA5678 after it.
- Async reset and out-of-range:
  - Write r3 = 0x00000042, then drop reset between clock edges -> rd1 (ra1 = 3) = 0 immediately, without a clock edge.
  - With Depth = 24: write 0x5 to wa = 30 -> no entry changes; ra1 = 30 -> rd1 = 0; ra1 = 14 -> rd1 = 0.
